// File: rtl/pio_input_debouncer.sv
// rtl/pio_input_debouncer.sv - per-channel synchronizer and debouncer feeding the PIO in_port
module pio_input_debouncer #(
    parameter int               WIDTH           = 10,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 1000000,
    parameter int               CNT_W           = 20,
    parameter logic [WIDTH-1:0] INVERT_MASK     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             busy
);

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced;

    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0] clean_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic [WIDTH-1:0] counting_d;

    // Stages reset to the inversion mask so that every channel reads inactive out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= INVERT_MASK;
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1] ^ INVERT_MASK;

    always_comb begin
        clean_d    = clean_out;
        rise_d     = '0;
        fall_d     = '0;
        counting_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                STABLE: begin
                    if (synced[i] != clean_out[i]) begin
                        state_d[i] = COUNTING;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                COUNTING: begin
                    if (synced[i] == clean_out[i]) begin
                        state_d[i] = STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        clean_d[i] = synced[i];
                        rise_d[i]  = synced[i];
                        fall_d[i]  = ~synced[i];
                        state_d[i] = STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
            counting_d[i] = (state_d[i] == COUNTING);
        end
    end

    // busy is registered from the next state so it tracks the COUNTING cycles exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
            clean_out  <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            busy       <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            clean_out  <= clean_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
            busy       <= |counting_d;
        end
    end

endmodule

// File: tb/tb_pio_input_debouncer.sv
// tb/tb_pio_input_debouncer.sv - directed self-checking bench for pio_input_debouncer
module tb_pio_input_debouncer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] raw0, raw1;
    logic [9:0] clean0, rise0, fall0, clean1, rise1, fall1;
    logic       busy0, busy1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    pio_input_debouncer #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .CNT_W(4),
                          .INVERT_MASK(10'h000)) dut0 (
        .clk(clk), .reset_n(reset_n), .raw_in(raw0), .clean_out(clean0),
        .rise_pulse(rise0), .fall_pulse(fall0), .busy(busy0));

    pio_input_debouncer #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .CNT_W(4),
                          .INVERT_MASK(10'h300)) dut1 (
        .clk(clk), .reset_n(reset_n), .raw_in(raw1), .clean_out(clean1),
        .rise_pulse(rise1), .fall_pulse(fall1), .busy(busy1));

    // Reset both DUTs with inactive inputs; returns just after the release edge (edge 0).
    task automatic do_reset();
        reset_n = 1'b0;
        raw0    = 10'h000;
        raw1    = 10'h300;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        raw0    = 10'h000;
        raw1    = 10'h300;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({clean0, rise0, fall0, busy0} !== 31'h0) begin
            errors++;
            $display("FAIL reset_during dut0: got clean=%h rise=%h fall=%h busy=%b, want all 0",
                     clean0, rise0, fall0, busy0);
        end
        checks++;
        if ({clean1, rise1, fall1, busy1} !== 31'h0) begin
            errors++;
            $display("FAIL reset_during dut1: got clean=%h rise=%h fall=%h busy=%b, want all 0",
                     clean1, rise1, fall1, busy1);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({clean0, rise0, fall0, busy0, clean1, rise1, fall1, busy1} !== 62'h0) begin
                errors++;
                $display("FAIL reset_after k=%0d: got clean0=%h clean1=%h busy0=%b busy1=%b, want all 0",
                         k, clean0, clean1, busy0, busy1);
            end
        end
    endtask

    task automatic test_rise_fall();
        logic [9:0] exp_clean, exp_rise, exp_fall;
        logic       exp_busy;
        do_reset();
        raw0[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            exp_clean = (k >= 10) ? 10'h001 : 10'h000;
            exp_rise  = (k == 10) ? 10'h001 : 10'h000;
            exp_busy  = (k >= 3 && k <= 9);
            checks++;
            if (clean0 !== exp_clean || rise0 !== exp_rise || fall0 !== 10'h000 || busy0 !== exp_busy) begin
                errors++;
                $display("FAIL rise k=%0d: got clean=%h rise=%h fall=%h busy=%b, want clean=%h rise=%h fall=000 busy=%b",
                         k, clean0, rise0, fall0, busy0, exp_clean, exp_rise, exp_busy);
            end
        end
        raw0[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            exp_clean = (k >= 10) ? 10'h000 : 10'h001;
            exp_fall  = (k == 10) ? 10'h001 : 10'h000;
            exp_busy  = (k >= 3 && k <= 9);
            checks++;
            if (clean0 !== exp_clean || fall0 !== exp_fall || rise0 !== 10'h000 || busy0 !== exp_busy) begin
                errors++;
                $display("FAIL fall k=%0d: got clean=%h rise=%h fall=%h busy=%b, want clean=%h rise=000 fall=%h busy=%b",
                         k, clean0, rise0, fall0, busy0, exp_clean, exp_fall, exp_busy);
            end
        end
    endtask

    task automatic test_bounce();
        logic [9:0] exp_clean, exp_rise;
        logic       exp_busy;
        do_reset();
        raw0[3] = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk); #1;
            exp_clean = (k >= 17) ? 10'h008 : 10'h000;
            exp_rise  = (k == 17) ? 10'h008 : 10'h000;
            exp_busy  = (k >= 3 && k <= 7) || (k >= 10 && k <= 16);
            checks++;
            if (clean0 !== exp_clean || rise0 !== exp_rise || fall0 !== 10'h000 || busy0 !== exp_busy) begin
                errors++;
                $display("FAIL bounce k=%0d: got clean=%h rise=%h fall=%h busy=%b, want clean=%h rise=%h fall=000 busy=%b",
                         k, clean0, rise0, fall0, busy0, exp_clean, exp_rise, exp_busy);
            end
            if (k == 5) raw0[3] = 1'b0;
            if (k == 7) raw0[3] = 1'b1;
        end
    endtask

    task automatic test_short_pulse();
        logic exp_busy;
        do_reset();
        raw0[5] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            exp_busy = (k >= 3 && k <= 9);
            checks++;
            if (clean0 !== 10'h000 || rise0 !== 10'h000 || fall0 !== 10'h000 || busy0 !== exp_busy) begin
                errors++;
                $display("FAIL short_pulse k=%0d: got clean=%h rise=%h fall=%h busy=%b, want clean=000 rise=000 fall=000 busy=%b",
                         k, clean0, rise0, fall0, busy0, exp_busy);
            end
            if (k == 7) raw0[5] = 1'b0;
        end
    endtask

    task automatic test_invert();
        logic [9:0] exp_clean, exp_rise;
        logic       exp_busy;
        do_reset();
        raw1[9] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            exp_clean = (k >= 10) ? 10'h200 : 10'h000;
            exp_rise  = (k == 10) ? 10'h200 : 10'h000;
            exp_busy  = (k >= 3 && k <= 9);
            checks++;
            if (clean1 !== exp_clean || rise1 !== exp_rise || fall1 !== 10'h000 || busy1 !== exp_busy) begin
                errors++;
                $display("FAIL invert k=%0d: got clean=%h rise=%h fall=%h busy=%b, want clean=%h rise=%h fall=000 busy=%b",
                         k, clean1, rise1, fall1, busy1, exp_clean, exp_rise, exp_busy);
            end
        end
    endtask

    task automatic test_back_to_back_reset();
        logic [9:0] exp_clean, exp_rise;
        logic       exp_busy;
        do_reset();
        raw0 = 10'h081;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy0 !== 1'b1 || clean0 !== 10'h000) begin
            errors++;
            $display("FAIL midreset_pre: got busy=%b clean=%h, want busy=1 clean=000", busy0, clean0);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({clean0, rise0, fall0, busy0} !== 31'h0) begin
            errors++;
            $display("FAIL midreset_async: got clean=%h rise=%h fall=%h busy=%b, want all 0",
                     clean0, rise0, fall0, busy0);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            exp_clean = (k >= 10) ? 10'h081 : 10'h000;
            exp_rise  = (k == 10) ? 10'h081 : 10'h000;
            exp_busy  = (k >= 3 && k <= 9);
            checks++;
            if (clean0 !== exp_clean || rise0 !== exp_rise || fall0 !== 10'h000 || busy0 !== exp_busy) begin
                errors++;
                $display("FAIL midreset k=%0d: got clean=%h rise=%h fall=%h busy=%b, want clean=%h rise=%h fall=000 busy=%b",
                         k, clean0, rise0, fall0, busy0, exp_clean, exp_rise, exp_busy);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        raw0    = 10'h000;
        raw1    = 10'h300;
        test_reset();
        test_rise_fall();
        test_bounce();
        test_short_pulse();
        test_invert();
        test_back_to_back_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
